// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter (inst/data) for one single-port SRAM with 1-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for alternating conflict resolution; default is data priority with a starvation guard.
module sram_port_arbiter #(
    parameter int ADDR_WD    = 32,
    parameter int DATA_WD    = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_req,
    input  logic [DATA_WD/8-1:0] inst_wen,
    input  logic [ADDR_WD-1:0]   inst_addr,
    input  logic [DATA_WD-1:0]   inst_wdata,
    output logic                 inst_gnt,
    output logic                 inst_rvalid,
    output logic [DATA_WD-1:0]   inst_rdata,
    input  logic                 data_req,
    input  logic [DATA_WD/8-1:0] data_wen,
    input  logic [ADDR_WD-1:0]   data_addr,
    input  logic [DATA_WD-1:0]   data_wdata,
    output logic                 data_gnt,
    output logic                 data_rvalid,
    output logic [DATA_WD-1:0]   data_rdata,
    output logic                 sram_en,
    output logic [DATA_WD/8-1:0] sram_wen,
    output logic [ADDR_WD-1:0]   sram_addr,
    output logic [DATA_WD-1:0]   sram_wdata,
    input  logic [DATA_WD-1:0]   sram_rdata
);

    logic               w_conflict;
    logic               w_inst_win;
    logic               w_inst_gnt;
    logic               w_data_gnt;
    logic [1:0]         r_rd_owner;
    logic [DATA_WD-1:0] r_inst_hold;
    logic [DATA_WD-1:0] r_data_hold;

    assign w_conflict = inst_req & data_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when data took the last conflict, so inst takes the next one.
    logic r_rr_last;

    assign w_inst_win = r_rr_last;

    always_ff @(posedge clk) begin
        if (reset)
            r_rr_last <= 1'b0;
        else if (w_conflict)
            r_rr_last <= w_data_gnt;
    end
`else
    logic [3:0] r_starve_cnt;

    assign w_inst_win = (r_starve_cnt == 4'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset || w_inst_gnt || !inst_req)
            r_starve_cnt <= 4'd0;
        else if (w_conflict)
            r_starve_cnt <= r_starve_cnt + 4'd1;
    end
`endif

    assign w_inst_gnt = !reset && inst_req && (!data_req || w_inst_win);
    assign w_data_gnt = !reset && data_req && (!inst_req || !w_inst_win);
    assign inst_gnt   = w_inst_gnt;
    assign data_gnt   = w_data_gnt;
    assign sram_en    = w_inst_gnt | w_data_gnt;

    always_comb begin
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_inst_gnt) begin
            sram_wen   = inst_wen;
            sram_addr  = inst_addr;
            sram_wdata = inst_wdata;
        end else if (w_data_gnt) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_rd_owner <= 2'b00;
        else
            r_rd_owner <= {w_data_gnt && !(|data_wen), w_inst_gnt && !(|inst_wen)};
    end

    // Gating with reset drops a read that was granted just before reset rose.
    assign inst_rvalid = r_rd_owner[0] && !reset;
    assign data_rvalid = r_rd_owner[1] && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_hold <= '0;
            r_data_hold <= '0;
        end else begin
            if (inst_rvalid) r_inst_hold <= sram_rdata;
            if (data_rvalid) r_data_hold <= sram_rdata;
        end
    end

    assign inst_rdata = reset ? '0 : (inst_rvalid ? sram_rdata : r_inst_hold);
    assign data_rdata = reset ? '0 : (data_rvalid ? sram_rdata : r_data_hold);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, single read, write, read-data hold, conflicts, reset mid-read.
module tb_sram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [3:0]  inst_wen;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int n_pass = 0;
    int n_total = 0;

    sram_port_arbiter #(.ADDR_WD(32), .DATA_WD(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100us");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        inst_req = 1'b0; inst_wen = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1; inst_req = 1'b1; data_req = 1'b1;
        #1;
        n_total++; if (inst_gnt !== 1'b0) $display("FAIL rst_inst_gnt: got %0h want 0", inst_gnt); else n_pass++;
        n_total++; if (data_gnt !== 1'b0) $display("FAIL rst_data_gnt: got %0h want 0", data_gnt); else n_pass++;
        n_total++; if (sram_en !== 1'b0) $display("FAIL rst_sram_en: got %0h want 0", sram_en); else n_pass++;
        next_cycle();
        #1;
        n_total++; if (inst_rvalid !== 1'b0) $display("FAIL rst_inst_rvalid: got %0h want 0", inst_rvalid); else n_pass++;
        n_total++; if (data_rvalid !== 1'b0) $display("FAIL rst_data_rvalid: got %0h want 0", data_rvalid); else n_pass++;
        n_total++; if (inst_rdata !== 32'h0) $display("FAIL rst_inst_rdata: got %0h want 0", inst_rdata); else n_pass++;
        n_total++; if (data_rdata !== 32'h0) $display("FAIL rst_data_rdata: got %0h want 0", data_rdata); else n_pass++;
        idle_inputs();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_read;
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000;
        #1;
        n_total++; if (inst_gnt !== 1'b1) $display("FAIL rd_inst_gnt: got %0h want 1", inst_gnt); else n_pass++;
        n_total++; if (data_gnt !== 1'b0) $display("FAIL rd_data_gnt: got %0h want 0", data_gnt); else n_pass++;
        n_total++; if (sram_en !== 1'b1) $display("FAIL rd_sram_en: got %0h want 1", sram_en); else n_pass++;
        n_total++; if (sram_addr !== 32'hbfc0_0000) $display("FAIL rd_sram_addr: got %0h want bfc00000", sram_addr); else n_pass++;
        n_total++; if (sram_wen !== 4'h0) $display("FAIL rd_sram_wen: got %0h want 0", sram_wen); else n_pass++;
        next_cycle();
        idle_inputs();
        sram_rdata = 32'h1111_2222;
        #1;
        n_total++; if (inst_rvalid !== 1'b1) $display("FAIL rd_inst_rvalid: got %0h want 1", inst_rvalid); else n_pass++;
        n_total++; if (inst_rdata !== 32'h1111_2222) $display("FAIL rd_inst_rdata: got %0h want 11112222", inst_rdata); else n_pass++;
        n_total++; if (data_rvalid !== 1'b0) $display("FAIL rd_data_rvalid: got %0h want 0", data_rvalid); else n_pass++;
        n_total++; if (sram_en !== 1'b0) $display("FAIL idle_sram_en: got %0h want 0", sram_en); else n_pass++;
        n_total++; if (sram_addr !== 32'h0) $display("FAIL idle_sram_addr: got %0h want 0", sram_addr); else n_pass++;
        next_cycle();
    endtask

    task automatic test_write;
        data_req = 1'b1; data_wen = 4'hf; data_addr = 32'h100; data_wdata = 32'hdead_beef;
        #1;
        n_total++; if (data_gnt !== 1'b1) $display("FAIL wr_data_gnt: got %0h want 1", data_gnt); else n_pass++;
        n_total++; if (sram_wen !== 4'hf) $display("FAIL wr_sram_wen: got %0h want f", sram_wen); else n_pass++;
        n_total++; if (sram_addr !== 32'h100) $display("FAIL wr_sram_addr: got %0h want 100", sram_addr); else n_pass++;
        n_total++; if (sram_wdata !== 32'hdead_beef) $display("FAIL wr_sram_wdata: got %0h want deadbeef", sram_wdata); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_total++; if (data_rvalid !== 1'b0) $display("FAIL wr_data_rvalid: got %0h want 0", data_rvalid); else n_pass++;
        n_total++; if (sram_wdata !== 32'h0) $display("FAIL idle_sram_wdata: got %0h want 0", sram_wdata); else n_pass++;
        next_cycle();
    endtask

    task automatic test_hold;
        inst_req = 1'b1; inst_addr = 32'h40;
        #1;
        n_total++; if (inst_gnt !== 1'b1) $display("FAIL hold_inst_gnt: got %0h want 1", inst_gnt); else n_pass++;
        next_cycle();
        idle_inputs();
        sram_rdata = 32'h1234;
        #1;
        n_total++; if (inst_rdata !== 32'h1234) $display("FAIL hold_first: got %0h want 1234", inst_rdata); else n_pass++;
        next_cycle();
        sram_rdata = 32'h5678; data_req = 1'b1; data_addr = 32'h44;
        #1;
        n_total++; if (inst_rvalid !== 1'b0) $display("FAIL hold_rvalid: got %0h want 0", inst_rvalid); else n_pass++;
        n_total++; if (inst_rdata !== 32'h1234) $display("FAIL hold_keep: got %0h want 1234", inst_rdata); else n_pass++;
        next_cycle();
        idle_inputs();
        sram_rdata = 32'habcd;
        #1;
        n_total++; if (data_rvalid !== 1'b1) $display("FAIL hold_data_rvalid: got %0h want 1", data_rvalid); else n_pass++;
        n_total++; if (data_rdata !== 32'habcd) $display("FAIL hold_data_rdata: got %0h want abcd", data_rdata); else n_pass++;
        n_total++; if (inst_rdata !== 32'h1234) $display("FAIL hold_keep2: got %0h want 1234", inst_rdata); else n_pass++;
        next_cycle();
        sram_rdata = 32'h0;
        #1;
        n_total++; if (data_rdata !== 32'habcd) $display("FAIL hold_data_keep: got %0h want abcd", data_rdata); else n_pass++;
        n_total++; if (inst_rdata !== 32'h1234) $display("FAIL hold_keep3: got %0h want 1234", inst_rdata); else n_pass++;
        next_cycle();
    endtask

    task automatic test_conflict;
        logic exp_inst;
        logic prev_inst;
        prev_inst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1000;
        data_req = 1'b1; data_addr = 32'h2000;
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_inst = (i % 2 == 1);
`else
            exp_inst = (i % 5 == 4);
`endif
            n_total++; if (inst_gnt !== exp_inst) $display("FAIL cf_inst_gnt[%0d]: got %0h want %0h", i, inst_gnt, exp_inst); else n_pass++;
            n_total++; if (data_gnt !== !exp_inst) $display("FAIL cf_data_gnt[%0d]: got %0h want %0h", i, data_gnt, !exp_inst); else n_pass++;
            n_total++; if (sram_addr !== (exp_inst ? 32'h1000 : 32'h2000)) $display("FAIL cf_sram_addr[%0d]: got %0h", i, sram_addr); else n_pass++;
            if (i > 0) begin
                n_total++; if (inst_rvalid !== prev_inst) $display("FAIL cf_inst_rvalid[%0d]: got %0h want %0h", i, inst_rvalid, prev_inst); else n_pass++;
                n_total++; if (data_rvalid !== !prev_inst) $display("FAIL cf_data_rvalid[%0d]: got %0h want %0h", i, data_rvalid, !prev_inst); else n_pass++;
            end
            prev_inst = exp_inst;
            next_cycle();
        end
        idle_inputs();
        #1;
        n_total++; if (inst_rvalid !== prev_inst) $display("FAIL cf_last_rvalid: got %0h want %0h", inst_rvalid, prev_inst); else n_pass++;
        next_cycle();
    endtask

`ifndef ARB_ROUND_ROBIN_EN
    // Dropping inst_req mid-streak must restart the starvation count.
    task automatic test_starve_clear;
        logic exp_inst;
        data_req = 1'b1;
        for (int s = 0; s < 8; s++) begin
            inst_req = (s != 2);
            exp_inst = (s == 7);
            #1;
            n_total++; if (inst_gnt !== exp_inst) $display("FAIL sc_inst_gnt[%0d]: got %0h want %0h", s, inst_gnt, exp_inst); else n_pass++;
            n_total++; if (data_gnt !== !exp_inst) $display("FAIL sc_data_gnt[%0d]: got %0h want %0h", s, data_gnt, !exp_inst); else n_pass++;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask
`endif

    task automatic test_reset_mid;
        inst_req = 1'b1; inst_addr = 32'h80;
        #1;
        n_total++; if (inst_gnt !== 1'b1) $display("FAIL rm_pre_gnt: got %0h want 1", inst_gnt); else n_pass++;
        next_cycle();
        reset = 1'b1; inst_req = 1'b0; data_req = 1'b1; sram_rdata = 32'h9999;
        #1;
        n_total++; if (inst_rvalid !== 1'b0) $display("FAIL rm_rvalid: got %0h want 0", inst_rvalid); else n_pass++;
        n_total++; if (inst_rdata !== 32'h0) $display("FAIL rm_rdata: got %0h want 0", inst_rdata); else n_pass++;
        n_total++; if (data_gnt !== 1'b0) $display("FAIL rm_data_gnt: got %0h want 0", data_gnt); else n_pass++;
        n_total++; if (sram_en !== 1'b0) $display("FAIL rm_sram_en: got %0h want 0", sram_en); else n_pass++;
        next_cycle();
        reset = 1'b0; data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h84;
        #1;
        n_total++; if (inst_gnt !== 1'b1) $display("FAIL rm_resume_gnt: got %0h want 1", inst_gnt); else n_pass++;
        n_total++; if (sram_addr !== 32'h84) $display("FAIL rm_resume_addr: got %0h want 84", sram_addr); else n_pass++;
        n_total++; if (inst_rvalid !== 1'b0) $display("FAIL rm_dropped: got %0h want 0", inst_rvalid); else n_pass++;
        n_total++; if (inst_rdata !== 32'h0) $display("FAIL rm_hold_clr: got %0h want 0", inst_rdata); else n_pass++;
        next_cycle();
        idle_inputs();
        sram_rdata = 32'h77;
        #1;
        n_total++; if (inst_rvalid !== 1'b1) $display("FAIL rm_post_rvalid: got %0h want 1", inst_rvalid); else n_pass++;
        n_total++; if (inst_rdata !== 32'h77) $display("FAIL rm_post_rdata: got %0h want 77", inst_rdata); else n_pass++;
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        sram_rdata = 32'h0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_write();
        test_hold();
        test_conflict();
`ifndef ARB_ROUND_ROBIN_EN
        test_starve_clear();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
